// File: rtl/kd_load_pkg.sv
// Shared constants, region sizes and state encoding for the KD-tree load sequencer.
package kd_load_pkg;
  localparam int unsigned DATA_WIDTH  = 11;
  localparam int unsigned PATCH_SIZE  = 5;
  localparam int unsigned LEAF_SIZE   = 8;
  localparam int unsigned NUM_LEAVES  = 64;
  localparam int unsigned NUM_QUERYS  = 494;
  localparam int unsigned NUM_NODES   = NUM_LEAVES - 1;

  localparam int unsigned NODE_WORDS  = 2;
  localparam int unsigned LEAF_WORDS  = 6;
  localparam int unsigned QUERY_WORDS = 5;

  localparam int unsigned PATCH_W     = PATCH_SIZE * DATA_WIDTH;
  localparam int unsigned NODE_AW     = 6;
  localparam int unsigned LEAF_AW     = 6;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned QUERY_AW    = 9;
  localparam int unsigned WORD_CNT_W  = 3;
  localparam int unsigned REC_CNT_W   = 9;

  typedef enum logic [2:0] {
    IDLE,
    NODES,
    LEAVES,
    QUERIES,
    DONE
  } load_state_t;
endpackage

// File: rtl/kd_load_ctrl_if.sv
// FIFO read port plus the three memory write ports driven by the load sequencer.
interface kd_load_ctrl_if;
  import kd_load_pkg::*;

  logic                  fifo_rempty_n;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_deq;

  logic                  node_wen;
  logic [NODE_AW-1:0]    node_waddr;
  logic [DATA_WIDTH-1:0] node_idx;
  logic [DATA_WIDTH-1:0] node_median;

  logic                  leaf_wen;
  logic [LEAF_AW-1:0]    leaf_waddr;
  logic [SEL_W-1:0]      leaf_patch_sel;
  logic [PATCH_W-1:0]    leaf_wpatch;
  logic [DATA_WIDTH-1:0] leaf_wpatch_idx;

  logic                  query_wen;
  logic [QUERY_AW-1:0]   query_waddr;
  logic [PATCH_W-1:0]    query_wpatch;

  modport master (
    input  fifo_rempty_n, fifo_rdata,
    output fifo_deq,
    output node_wen, node_waddr, node_idx, node_median,
    output leaf_wen, leaf_waddr, leaf_patch_sel, leaf_wpatch, leaf_wpatch_idx,
    output query_wen, query_waddr, query_wpatch
  );

  modport slave (
    output fifo_rempty_n, fifo_rdata,
    input  fifo_deq,
    input  node_wen, node_waddr, node_idx, node_median,
    input  leaf_wen, leaf_waddr, leaf_patch_sel, leaf_wpatch, leaf_wpatch_idx,
    input  query_wen, query_waddr, query_wpatch
  );
endinterface

// File: rtl/kd_load_ctrl_word_packer.sv
// Shift-in register of PATCH_SIZE words; the oldest word ends up in the LSBs.
module word_packer
  import kd_load_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [PATCH_W-1:0]    data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift) begin
      data <= {din, data[PATCH_W-1:DATA_WIDTH]};
    end
  end
endmodule

// File: rtl/kd_load_ctrl.sv
// Load-phase sequencer: drains the input FIFO into node, leaf and query memories
// in fixed order, one registered write per completed record.
module kd_load_ctrl
  import kd_load_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_kdtree,
  kd_load_ctrl_if.master bus,
  output logic           busy,
  output logic           load_done
);
  localparam logic [REC_CNT_W-1:0]  LAST_NODE  = REC_CNT_W'(NUM_NODES - 1);
  localparam logic [REC_CNT_W-1:0]  LAST_LEAF  = REC_CNT_W'(NUM_LEAVES * LEAF_SIZE - 1);
  localparam logic [REC_CNT_W-1:0]  LAST_QUERY = REC_CNT_W'(NUM_QUERYS - 1);
  localparam logic [WORD_CNT_W-1:0] NODE_LAST  = WORD_CNT_W'(NODE_WORDS - 1);
  localparam logic [WORD_CNT_W-1:0] LEAF_LAST  = WORD_CNT_W'(LEAF_WORDS - 1);
  localparam logic [WORD_CNT_W-1:0] QUERY_LAST = WORD_CNT_W'(QUERY_WORDS - 1);

  load_state_t           state;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [REC_CNT_W-1:0]  rec_cnt;
  logic [DATA_WIDTH-1:0] idx_hold;
  logic [PATCH_W-1:0]    pk_data;
  logic [PATCH_W-1:0]    pk_next_c;
  logic                  pop_c;
  logic                  pk_shift_c;

  // A restart pulse suppresses the pop so the head word becomes word 0 of node 0.
  assign pop_c        = bus.fifo_rempty_n & busy & ~load_kdtree;
  assign bus.fifo_deq = pop_c;

  // The sixth leaf word is the patch index and never enters the packer.
  assign pk_shift_c = pop_c & (((state == LEAVES) && (word_cnt != LEAF_LAST)) ||
                               (state == QUERIES));
  assign pk_next_c  = {bus.fifo_rdata, pk_data[PATCH_W-1:DATA_WIDTH]};

  word_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load_kdtree),
    .shift (pk_shift_c),
    .din   (bus.fifo_rdata),
    .data  (pk_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      busy                <= 1'b0;
      load_done           <= 1'b0;
      word_cnt            <= '0;
      rec_cnt             <= '0;
      idx_hold            <= '0;
      bus.node_wen        <= 1'b0;
      bus.node_waddr      <= '0;
      bus.node_idx        <= '0;
      bus.node_median     <= '0;
      bus.leaf_wen        <= 1'b0;
      bus.leaf_waddr      <= '0;
      bus.leaf_patch_sel  <= '0;
      bus.leaf_wpatch     <= '0;
      bus.leaf_wpatch_idx <= '0;
      bus.query_wen       <= 1'b0;
      bus.query_waddr     <= '0;
      bus.query_wpatch    <= '0;
    end else begin
      bus.node_wen  <= 1'b0;
      bus.leaf_wen  <= 1'b0;
      bus.query_wen <= 1'b0;
      if (load_kdtree) begin
        state     <= NODES;
        busy      <= 1'b1;
        load_done <= 1'b0;
        word_cnt  <= '0;
        rec_cnt   <= '0;
      end else if (pop_c) begin
        unique case (state)
          NODES: begin
            if (word_cnt != NODE_LAST) begin
              idx_hold <= bus.fifo_rdata;
              word_cnt <= word_cnt + WORD_CNT_W'(1);
            end else begin
              bus.node_wen    <= 1'b1;
              bus.node_waddr  <= rec_cnt[NODE_AW-1:0];
              bus.node_idx    <= idx_hold;
              bus.node_median <= bus.fifo_rdata;
              word_cnt        <= '0;
              if (rec_cnt == LAST_NODE) begin
                rec_cnt <= '0;
                state   <= LEAVES;
              end else begin
                rec_cnt <= rec_cnt + REC_CNT_W'(1);
              end
            end
          end
          LEAVES: begin
            if (word_cnt != LEAF_LAST) begin
              word_cnt <= word_cnt + WORD_CNT_W'(1);
            end else begin
              bus.leaf_wen        <= 1'b1;
              bus.leaf_waddr      <= rec_cnt[REC_CNT_W-1:SEL_W];
              bus.leaf_patch_sel  <= rec_cnt[SEL_W-1:0];
              bus.leaf_wpatch     <= pk_data;
              bus.leaf_wpatch_idx <= bus.fifo_rdata;
              word_cnt            <= '0;
              if (rec_cnt == LAST_LEAF) begin
                rec_cnt <= '0;
                state   <= QUERIES;
              end else begin
                rec_cnt <= rec_cnt + REC_CNT_W'(1);
              end
            end
          end
          QUERIES: begin
            if (word_cnt != QUERY_LAST) begin
              word_cnt <= word_cnt + WORD_CNT_W'(1);
            end else begin
              bus.query_wen    <= 1'b1;
              bus.query_waddr  <= rec_cnt;
              bus.query_wpatch <= pk_next_c;
              word_cnt         <= '0;
              if (rec_cnt == LAST_QUERY) begin
                rec_cnt   <= '0;
                state     <= DONE;
                busy      <= 1'b0;
                load_done <= 1'b1;
              end else begin
                rec_cnt <= rec_cnt + REC_CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
